hazard_stall_controller: RTL and testbench

- Central hazard sequencer for the RV32IM 5-stage pipeline.
- Drives PC write-enable, the IF/ID register's BUBBLE (hold) input, and flush and stall controls for IF/ID, ID/EX and EX.
- Detects load-use hazards and taken-branch redirects.
- Sequences multi-cycle DIV/REM operations with a start/done handshake and a timeout watchdog.
- Provides stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/load_use_detect.sv | 25 ++
 rtl/hazard_stall_controller.sv | 132 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          DEF_REG_ADDR_W = 5;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID operand that depends on a load now in EX.
// Kept standalone so a forwarding unit can reuse the same match logic.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  lu
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency, so a load targeting it cannot stall.
  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    lu      = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central hazard sequencer: load-use stalls, branch flushes, multi-cycle
// DIV/REM start/done sequencing with watchdog, and stall/flush counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MEM_READ,
  input  logic                  EX_IS_MULDIV,
  input  logic                  MD_DONE,
  input  logic                  BRANCH_TAKEN,
  output logic                  PC_WRITE,
  output logic                  IFID_BUBBLE,
  output logic                  IFID_FLUSH,
  output logic                  IDEX_FLUSH,
  output logic                  EX_STALL,
  output logic                  MD_START,
  output logic                  MD_TIMEOUT_ERR,
  output logic [CNT_W-1:0]      STALL_CYCLES,
  output logic [15:0]           FLUSH_COUNT
);

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             lu;
  logic             wd_expire;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
    .id_rs1      (ID_RS1),
    .id_rs2      (ID_RS2),
    .id_uses_rs1 (ID_USES_RS1),
    .id_uses_rs2 (ID_USES_RS2),
    .ex_rd       (EX_RD),
    .ex_mem_read (EX_MEM_READ),
    .lu          (lu)
  );

  // Watchdog fires on the last allowed wait cycle; a coincident MD_DONE wins.
  always_comb begin
    wd_expire = (state == MD_WAIT) && !MD_DONE &&
                (wd_cnt == CNT_W'(MD_TIMEOUT - 1));
  end

  // Pipeline controls: combinational from state and hazard inputs.
  always_comb begin
    PC_WRITE    = 1'b1;
    IFID_BUBBLE = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EX_STALL    = 1'b0;
    MD_START    = 1'b0;
    if (!RESET) begin
      case (state)
        RUN: begin
          if (BRANCH_TAKEN) begin
            // ID instruction is squashed, so any load-use on it is moot.
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else if (EX_IS_MULDIV) begin
            MD_START    = 1'b1;
            PC_WRITE    = 1'b0;
            IFID_BUBBLE = 1'b1;
            EX_STALL    = 1'b1;
          end else if (lu) begin
            PC_WRITE    = 1'b0;
            IFID_BUBBLE = 1'b1;
            IDEX_FLUSH  = 1'b1;
          end
        end
        MD_WAIT: begin
          // On done or timeout the stall drops so EX/MEM captures this edge.
          if (!MD_DONE && !wd_expire) begin
            PC_WRITE    = 1'b0;
            IFID_BUBBLE = 1'b1;
            EX_STALL    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, watchdog counter and sticky timeout flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= RUN;
      wd_cnt         <= '0;
      MD_TIMEOUT_ERR <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!BRANCH_TAKEN && EX_IS_MULDIV) begin
            state  <= MD_WAIT;
            wd_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (MD_DONE) begin
            state <= RUN;
          end else if (wd_expire) begin
            state          <= RUN;
            MD_TIMEOUT_ERR <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Performance counters; both wrap naturally at their width.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_CYCLES <= '0;
      FLUSH_COUNT  <= '0;
    end else begin
      if (!PC_WRITE) STALL_CYCLES <= STALL_CYCLES + 1'b1;
      if ((state == RUN) && BRANCH_TAKEN) FLUSH_COUNT <= FLUSH_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: two controllers (long and short watchdog) share stimulus;
// a rule-level reference model predicts each cycle, a monitor compares.
module tb_hazard_stall_controller;

  localparam int TMO_A = 64;
  localparam int TMO_B = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_u1 = 0, id_u2 = 0, ex_mr = 0, ex_md = 0, md_done = 0, br = 0;

  logic [5:0]  a_ctl, b_ctl;
  logic        a_err, b_err;
  logic [31:0] a_st, b_st;
  logic [15:0] a_fl, b_fl;

  always #5 CLK = ~CLK;

  hazard_stall_controller #(.MD_TIMEOUT(TMO_A), .REG_ADDR_W(5), .CNT_W(32)) dut_a (
    .CLK(CLK), .RESET(RESET), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_USES_RS1(id_u1), .ID_USES_RS2(id_u2), .EX_RD(ex_rd), .EX_MEM_READ(ex_mr),
    .EX_IS_MULDIV(ex_md), .MD_DONE(md_done), .BRANCH_TAKEN(br),
    .PC_WRITE(a_ctl[5]), .IFID_BUBBLE(a_ctl[4]), .IFID_FLUSH(a_ctl[3]),
    .IDEX_FLUSH(a_ctl[2]), .EX_STALL(a_ctl[1]), .MD_START(a_ctl[0]),
    .MD_TIMEOUT_ERR(a_err), .STALL_CYCLES(a_st), .FLUSH_COUNT(a_fl));

  hazard_stall_controller #(.MD_TIMEOUT(TMO_B), .REG_ADDR_W(5), .CNT_W(32)) dut_b (
    .CLK(CLK), .RESET(RESET), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_USES_RS1(id_u1), .ID_USES_RS2(id_u2), .EX_RD(ex_rd), .EX_MEM_READ(ex_mr),
    .EX_IS_MULDIV(ex_md), .MD_DONE(md_done), .BRANCH_TAKEN(br),
    .PC_WRITE(b_ctl[5]), .IFID_BUBBLE(b_ctl[4]), .IFID_FLUSH(b_ctl[3]),
    .IDEX_FLUSH(b_ctl[2]), .EX_STALL(b_ctl[1]), .MD_START(b_ctl[0]),
    .MD_TIMEOUT_ERR(b_err), .STALL_CYCLES(b_st), .FLUSH_COUNT(b_fl));

  // Reference model state: "waiting on divider" flag plus elapsed wait cycles.
  typedef struct {
    bit          waiting;
    int          wd;
    bit          err;
    logic [31:0] st;
    logic [15:0] fl;
  } mst_t;

  typedef struct {
    logic [5:0]  ctl;   // {pc_write, ifid_bubble, ifid_flush, idex_flush, ex_stall, md_start}
    logic        err;
    logic [31:0] st;
    logic [15:0] fl;
  } exp_t;

  mst_t ma, mb;
  exp_t qa[$], qb[$];

  int n_chk = 0, n_fail = 0;
  int cycn = 0, starts_a = 0, last1 = 0, last2 = 0;
  bit auto_done = 0, rand_lat = 0;
  int md_lat = 1, md_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cycn);
    end
  endtask

  function automatic void mreset(output mst_t m);
    m.waiting = 0; m.wd = 0; m.err = 0; m.st = '0; m.fl = '0;
  endfunction

  // One cycle of the control rules, written directly from the hazard priorities.
  function automatic void step(input mst_t s, input int tmo, input logic done,
                               input logic lu, output logic [5:0] ctl, output mst_t n);
    ctl = 6'b100000;
    n = s;
    if (!s.waiting) begin
      if (br) begin
        ctl = 6'b101100;
        n.fl = s.fl + 16'd1;
      end else if (ex_md) begin
        ctl = 6'b010011;
        n.waiting = 1; n.wd = 0;
      end else if (lu) begin
        ctl = 6'b010100;
      end
    end else begin
      if (done) n.waiting = 0;
      else if (s.wd == tmo - 1) begin n.waiting = 0; n.err = 1; end
      else begin ctl = 6'b010010; n.wd = s.wd + 1; end
    end
    if (!ctl[5]) n.st = s.st + 32'd1;
  endfunction

  function automatic exp_t mk(input logic [5:0] ctl, input mst_t s);
    exp_t e;
    e.ctl = ctl; e.err = s.err; e.st = s.st; e.fl = s.fl;
    return e;
  endfunction

  task automatic cyc(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                     input logic u2, input logic [4:0] rd, input logic mr,
                     input logic md, input logic done, input logic b);
    logic [5:0] ca, cb;
    mst_t na, nb;
    logic lu;
    RESET = 0;
    id_rs1 = r1; id_rs2 = r2; id_u1 = u1; id_u2 = u2; ex_rd = rd; ex_mr = mr;
    ex_md = md; br = b;
    if (ma.waiting) md_cnt++;
    md_done = auto_done ? (ma.waiting && md_cnt == md_lat) : done;
    lu = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    step(ma, TMO_A, md_done, lu, ca, na);
    step(mb, TMO_B, md_done, lu, cb, nb);
    qa.push_back(mk(ca, ma));
    qb.push_back(mk(cb, mb));
    if (na.waiting && !ma.waiting) begin
      md_cnt = 0;
      if (rand_lat) md_lat = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 20);
    end
    @(posedge CLK); #1;
    ma = na; mb = nb;
  endtask

  task automatic do_reset(input int n);
    mst_t z;
    RESET = 1;
    mreset(z);
    ma = z; mb = z; md_cnt = 0;
    for (int i = 0; i < n; i++) begin
      qa.push_back(mk(6'b100000, z));
      qb.push_back(mk(6'b100000, z));
      @(posedge CLK); #1;
    end
  endtask

  // Monitor: every cycle the DUT presents controls; compare against the queue.
  always @(negedge CLK) begin
    exp_t e;
    cycn++;
    if (a_ctl[0]) begin starts_a++; last2 = last1; last1 = cycn; end
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("dut_a outputs", {a_ctl, a_err, a_st, a_fl}, {e.ctl, e.err, e.st, e.fl});
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("dut_b outputs", {b_ctl, b_err, b_st, b_fl}, {e.ctl, e.err, e.st, e.fl});
    end
  end

  initial begin
    int s0;
    mreset(ma); mreset(mb);
    @(posedge CLK); #1;
    do_reset(2);
    chk("reset stall", a_st, 0);
    chk("reset pc_write", a_ctl[5], 1);

    // Load-use on rs1, then same pattern with rd=x0, then branch overriding LU.
    cyc(5, 7, 1, 1, 5, 1, 0, 0, 0);
    chk("lu stall count", a_st, 1);
    cyc(0, 7, 1, 1, 0, 1, 0, 0, 0);
    chk("x0 no stall", a_st, 1);
    cyc(5, 7, 1, 1, 5, 1, 0, 0, 1);
    chk("branch flush count", a_fl, 1);
    chk("branch no stall", a_st, 1);

    // DIV with 33-cycle latency.
    do_reset(1);
    s0 = starts_a;
    auto_done = 1; md_lat = 33;
    for (int i = 0; i < 34; i++) cyc(1, 2, 1, 1, 3, 0, 1, 0, 0);
    cyc(1, 2, 1, 1, 3, 0, 0, 0, 0);
    chk("div33 stall cycles", a_st, 33);
    chk("div33 one start", starts_a - s0, 1);

    // Never-completing DIV: short watchdog trips after 8 stall cycles.
    do_reset(1);
    md_lat = 1000;
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout err set", b_err, 1);
    chk("timeout stall", b_st, 8);
    chk("no err long wd", a_err, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout err sticky", b_err, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("second div stall", b_st, 9);

    // Reset in the 5th wait cycle, then a late MD_DONE in RUN.
    do_reset(1);
    md_lat = 1000;
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    chk("midwait reset stall", a_st, 0);
    auto_done = 0;
    s0 = starts_a;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("no start after reset", starts_a - s0, 0);
    chk("late done ignored", a_st, 0);

    // Back-to-back DIVs, latency 5.
    auto_done = 1; md_lat = 5;
    s0 = starts_a;
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b start count", starts_a - s0, 2);
    chk("b2b start spacing", last1 - last2, 6);

    // Randomized traffic with random divider latencies and occasional resets.
    do_reset(1);
    rand_lat = 1; md_lat = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 2));
      else begin
        logic nd;
        nd = !ma.waiting && ($urandom_range(0, 15) == 0);
        auto_done = !nd;
        cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 9) == 0, nd, $urandom_range(0, 7) == 0);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); #1;
    chk("queue drained", qa.size() + qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
